f2d_reg: RTL

Fetch-to-decode pipeline register for the five-stage MIPS core with precise exceptions. It sits directly downstream of the instruction fetch unit and the instruction memory port. Each cycle it captures the fetched PC, the instruction word, the fetch-stage exception and the delay-slot flag, and presents them to the decode stage. It holds its contents under a pipeline stall. On an exception or interrupt request it flushes to a bubble tagged with the handler address.

---
 rtl/f2d_reg.sv | 57 +++++
 1 files changed

// File: rtl/f2d_reg.sv
// Fetch-to-decode pipeline register: captures PC, instruction, fetch fault and delay-slot flag.
// Optional macro F2D_BD_EN keeps a real d_bd flop; otherwise d_bd is tied to 0.
module f2d_reg #(
  parameter logic [31:0] RESET_PC   = 32'h0000_3000,
  parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
  parameter logic [4:0]  EXC_ADEL   = 5'd4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        req,
  input  logic [31:0] f_pc,
  input  logic [31:0] f_instr,
  input  logic        f_exc_adel,
  input  logic        f_bd,
  output logic [31:0] d_pc,
  output logic [31:0] d_instr,
  output logic [4:0]  d_exccode,
  output logic        d_bd,
  output logic        d_valid
);

  always_ff @(posedge clk) begin
    if (rst) begin
      d_pc      <= RESET_PC;
      d_instr   <= 32'h0;
      d_exccode <= 5'd0;
      d_valid   <= 1'b0;
    end else if (req) begin
      d_pc      <= HANDLER_PC;
      d_instr   <= 32'h0;
      d_exccode <= 5'd0;
      d_valid   <= 1'b0;
    end else if (!stall) begin
      // A faulting fetch travels on as a nop carrying its exception code.
      d_pc      <= f_pc;
      d_instr   <= f_exc_adel ? 32'h0 : f_instr;
      d_exccode <= f_exc_adel ? EXC_ADEL : 5'd0;
      d_valid   <= 1'b1;
    end
  end

`ifdef F2D_BD_EN
  always_ff @(posedge clk) begin
    if (rst || req) begin
      d_bd <= 1'b0;
    end else if (!stall) begin
      d_bd <= f_bd;
    end
  end
`else
  assign d_bd = 1'b0;
  logic unused_bd;
  assign unused_bd = f_bd;
`endif

endmodule
